// File: rtl/sysid_reader.sv
// sysid_reader: Avalon-MM master that reads the sysid peripheral (word 0 = system
// ID, word 1 = build timestamp), compares both words against expected values and
// reports pass / mismatch / timeout to the board status logic.
module sysid_reader #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1445573127,
  parameter int unsigned TIMEOUT_CYCLES     = 256,
  parameter int unsigned CNT_W              = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  logic        id_mismatch_nx, ts_mismatch_nx, timeout_nx;
  logic [31:0] id_value_nx, ts_value_nx;
  logic        avm_read_nx, avm_address_nx, busy_nx, done_nx, pass_nx;

  // State, counter and all outputs are registered; avm_read drops with reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      avm_read    <= 1'b0;
      avm_address <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      avm_read    <= avm_read_nx;
      avm_address <= avm_address_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      pass        <= pass_nx;
      id_mismatch <= id_mismatch_nx;
      ts_mismatch <= ts_mismatch_nx;
      timeout     <= timeout_nx;
      id_value    <= id_value_nx;
      ts_value    <= ts_value_nx;
    end
  end

  // Next-state, capture and timeout logic; bus/status outputs are decoded from
  // the next state so they register alongside it.
  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    id_mismatch_nx = id_mismatch;
    ts_mismatch_nx = ts_mismatch;
    timeout_nx     = timeout;
    id_value_nx    = id_value;
    ts_value_nx    = ts_value;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx       = RD_ID;
          cnt_nx         = '0;
          id_mismatch_nx = 1'b0;
          ts_mismatch_nx = 1'b0;
          timeout_nx     = 1'b0;
          id_value_nx    = '0;
          ts_value_nx    = '0;
        end
      end
      RD_ID: begin
        if (!avm_waitrequest) begin
          id_value_nx    = avm_readdata;
          id_mismatch_nx = (avm_readdata != EXPECTED_ID);
          cnt_nx         = '0;
          state_nx       = RD_TS;
        end else if (cnt == CNT_LAST) begin
          timeout_nx = 1'b1;
          state_nx   = DONE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      RD_TS: begin
        if (!avm_waitrequest) begin
          ts_value_nx    = avm_readdata;
          ts_mismatch_nx = (avm_readdata != EXPECTED_TIMESTAMP);
          cnt_nx         = '0;
          state_nx       = DONE;
        end else if (cnt == CNT_LAST) begin
          timeout_nx = 1'b1;
          state_nx   = DONE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase

    avm_read_nx    = (state_nx == RD_ID) || (state_nx == RD_TS);
    avm_address_nx = (state_nx == RD_TS);
    busy_nx        = avm_read_nx;
    done_nx        = (state_nx == DONE);
    pass_nx        = done_nx && !(id_mismatch_nx || ts_mismatch_nx || timeout_nx);
  end

endmodule

// File: doc/sysid_reader.md
Name: sysid_reader

Overview:
- Avalon-MM master that reads the system ID peripheral and checks the result after boot or on demand.
- Reads word 0 (system ID), then word 1 (build timestamp), and compares each against parameterised expected values.
- Reports pass, mismatch or timeout to the status/LED logic.
- Sits between the board supervisor and the sysid control_slave in the Qsys fabric.

Parameters:
EXPECTED_ID, 32'd0, value required at sysid address 0
EXPECTED_TIMESTAMP, 32'd1445573127, value required at sysid address 1
TIMEOUT_CYCLES, 256, max consecutive waitrequest-high cycles per read before abort (>=1)
CNT_W, 9, width of timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle request to begin a check sequence
avm_address  out  1  sysid word select (0 = ID, 1 = timestamp)
avm_read  out  1  Avalon read strobe
avm_readdata  in  32  read data; valid in the cycle avm_read=1 and avm_waitrequest=0
avm_waitrequest  in  1  slave stall
busy  out  1  sequence in progress
done  out  1  sequence complete; held until next accepted start
pass  out  1  both words matched; valid when done=1
id_mismatch  out  1  word 0 differed from EXPECTED_ID
ts_mismatch  out  1  word 1 differed from EXPECTED_TIMESTAMP
timeout  out  1  a read exceeded TIMEOUT_CYCLES
id_value  out  32  captured word 0
ts_value  out  32  captured word 1

Behaviour:
- Reset values: all outputs 0, state IDLE, counter 0. Reset is asynchronous at any point, including mid-read; avm_read drops immediately with reset.
- State IDLE:
  - start=1 -> RD_ID at the next edge.
  - Accepting start clears done, pass, all three flags, id_value and ts_value.
- State RD_ID:
  - Drive avm_read=1, avm_address=0, busy=1.
  - If avm_waitrequest=0, capture avm_readdata into id_value, set id_mismatch = (readdata != EXPECTED_ID), and go to RD_TS.
  - Otherwise increment the counter.
- State RD_TS: same as RD_ID with avm_address=1, ts_value, ts_mismatch and EXPECTED_TIMESTAMP; on accept go to DONE.
- Zero-wait-state slave: the sequence accepts at most one read per cycle.
  - avm_read is high for exactly 2 consecutive cycles (RD_ID then RD_TS).
  - done rises on the 3rd edge after the start edge.
- Address/read hold: avm_address and avm_read are registered outputs and stay stable while avm_waitrequest=1.
- Timeout:
  - The counter clears on entry to each read state.
  - If waitrequest is still 1 in the cycle where the counter equals TIMEOUT_CYCLES-1, deassert avm_read at the next edge, set timeout=1, skip remaining reads and go to DONE.
  - Unread values stay 0 and their mismatch flags stay 0.
- State DONE:
  - done=1, busy=0, pass = !(id_mismatch | ts_mismatch | timeout).
  - start=1 restarts exactly as from IDLE.
- start while busy=1 is ignored; no queuing.
- Flags and values are registered; no output depends combinationally on avm_readdata.

Test Plan:
- Zero-wait slave returning 0 / 1445573127:
  - Pulse start -> avm_read high 2 cycles (address 0 then 1).
  - done=1 on the 3rd edge after start; pass=1; id_value=0; ts_value=1445573127.
- Slave returns 0x00000005 at address 0 -> id_mismatch=1, ts_mismatch=0, pass=0, id_value=5.
- Waitrequest held high 3 cycles on each read:
  - Address and read stable throughout; each word captured once; done after 8 read-active cycles.
  - pass=1; no timeout.
- TIMEOUT_CYCLES=4, waitrequest stuck high on address 1:
  - avm_read drops after 4 cycles in RD_TS; timeout=1, pass=0.
  - id_value captured; ts_value=0.
- start pulsed during RD_TS -> ignored; a single sequence completes. Second start in DONE -> outputs clear and the sequence repeats.
- reset asserted mid-RD_ID while avm_read=1:
  - avm_read=0 asynchronously; all outputs 0.
  - After release, no read occurs until start.
